// File: rtl/sr_latch_driver.sv
// sr_latch_driver: valid/ready controlled set/reset pulse driver for an external SR latch.
// Optional SR_LATCH_DRIVER_SKIP_EN: complete at once when the latch already holds the target.

module sr_latch_driver #(
    parameter int PULSE_W   = 2,
    parameter int SETTLE    = 1,
    parameter int MAX_RETRY = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic req_valid,
    input  logic req_value,
    output logic req_ready,
    output logic s,
    output logic r,
    input  logic q_in,
    input  logic qbar_in,
    output logic busy,
    output logic done,
    output logic error
);

    localparam int MAXC = (PULSE_W > SETTLE) ? PULSE_W : SETTLE;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_SETTLE,
        ST_CHECK
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [RW-1:0] retry;
    logic [RW-1:0] retry_nxt;
    logic          tgt;
    logic          tgt_nxt;
    logic          accept;
    logic          pass;
    logic          skip;
    logic          s_nxt;
    logic          r_nxt;
    logic          done_nxt;
    logic          error_nxt;

    assign req_ready = (state == ST_IDLE);
    assign busy      = ~req_ready;
    assign accept    = req_valid && req_ready;

    // Readback qualification: unknown or non-complementary levels never pass.
    always_comb begin
        pass = 1'b0;
        skip = 1'b0;
        if ((q_in == tgt) && (qbar_in != tgt)) begin
            pass = 1'b1;
        end
`ifdef SR_LATCH_DRIVER_SKIP_EN
        if ((q_in == req_value) && (qbar_in != req_value)) begin
            skip = 1'b1;
        end
`endif
    end

    // State register with target, phase counter and retry counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            retry <= '0;
            tgt   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            retry <= retry_nxt;
            tgt   <= tgt_nxt;
        end
    end

    // Next-state logic: pulse, optional settle, then check with bounded retry.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        retry_nxt = retry;
        tgt_nxt   = tgt;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    tgt_nxt   = req_value;
                    retry_nxt = '0;
                    cnt_nxt   = '0;
                    if (!skip) begin
                        state_nxt = ST_PULSE;
                    end
                end
            end
            ST_PULSE: begin
                if (cnt == PULSE_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = (SETTLE == 0) ? ST_CHECK : ST_SETTLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_CHECK;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_CHECK: begin
                cnt_nxt = '0;
                if (pass) begin
                    state_nxt = ST_IDLE;
                end else if (retry == RETRY_MAX) begin
                    state_nxt = ST_IDLE;
                end else begin
                    retry_nxt = retry + 1'b1;
                    state_nxt = ST_PULSE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode: s/r only while the next state is PULSE, so never both.
    always_comb begin
        s_nxt     = (state_nxt == ST_PULSE) && tgt_nxt;
        r_nxt     = (state_nxt == ST_PULSE) && !tgt_nxt;
        done_nxt  = 1'b0;
        error_nxt = 1'b0;
        if (accept && skip) begin
            done_nxt = 1'b1;
        end
        if (state == ST_CHECK) begin
            if (pass) begin
                done_nxt = 1'b1;
            end else if (retry == RETRY_MAX) begin
                error_nxt = 1'b1;
            end
        end
    end

    // Registered latch drive and completion pulses; reset drops them at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s     <= 1'b0;
            r     <= 1'b0;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            s     <= s_nxt;
            r     <= r_nxt;
            done  <= done_nxt;
            error <= error_nxt;
        end
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver: vector table, hand sequences and random requests against a
// behavioural SR latch model and a completion-time reference model.

module tb_sr_latch_driver;

    localparam int PW = 2;
    localparam int ST = 1;
    localparam int MR = 3;
`ifdef SR_LATCH_DRIVER_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic req_valid = 1'b0;
    logic req_value = 1'b0;
    logic req_ready;
    logic s;
    logic r;
    logic q_in;
    logic qbar_in;
    logic busy;
    logic done;
    logic error;

    int checks = 0;
    int errors = 0;

    sr_latch_driver #(
        .PULSE_W  (PW),
        .SETTLE   (ST),
        .MAX_RETRY(MR)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req_valid(req_valid),
        .req_value(req_value),
        .req_ready(req_ready),
        .s        (s),
        .r        (r),
        .q_in     (q_in),
        .qbar_in  (qbar_in),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clock = ~clock;

    // Latch model: follows s/r one edge later, may ignore pulses or be overridden.
    logic q_m = 1'b0;
    logic prev_sr = 1'b0;
    int   total_pulses = 0;
    int   cur_idx = 0;
    int   ign_until = 0;
    logic ovr_en = 1'b0;
    logic ovr_q = 1'b0;
    logic ovr_qb = 1'b1;
    logic ign_now;

    assign ign_now = ((s | r) && !prev_sr) ? (total_pulses < ign_until)
                                           : (cur_idx < ign_until);
    assign q_in    = ovr_en ? ovr_q : q_m;
    assign qbar_in = ovr_en ? ovr_qb : ~q_m;

    always @(posedge clock) begin
        prev_sr <= s | r;
        if ((s | r) && !prev_sr) begin
            total_pulses <= total_pulses + 1;
            cur_idx      <= total_pulses;
        end
        if ((s | r) && !ign_now) begin
            q_m <= s;
        end
    end

    // Monitor: pulse counts and safety invariants.
    logic s_q = 1'b0;
    logic r_q = 1'b0;
    int   s_rise = 0;
    int   r_rise = 0;
    int   viol = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;

    always @(negedge clock) begin
        s_q <= s;
        r_q <= r;
        if (s && !s_q) s_rise <= s_rise + 1;
        if (r && !r_q) r_rise <= r_rise + 1;
        if ((s && r) || (done && error)) viol <= viol + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (error) err_cnt <= err_cnt + 1;
    end

    typedef struct {
        bit v;
        bit ovr;
        int k;
        bit oq;
        bit oqb;
        bit holds;
        int edone;
        int ecyc;
        int ep;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic configure(input bit ovr, input int k, input bit oq, input bit oqb);
        ovr_en    = ovr;
        ovr_q     = oq;
        ovr_qb    = oqb;
        ign_until = ovr ? total_pulses : total_pulses + k;
    endtask

    // Spec-level reference: attempts needed, then completion cycle from the formula.
    function automatic void predict(input bit holds, input bit ovr, input int k,
                                    output int ed, output int ec, output int ep);
        int first_ok;
        int att;
        if (SKIP && holds) begin
            ed = 1;
            ec = 1;
            ep = 0;
        end else begin
            first_ok = holds ? 1 : (ovr ? 1000 : k + 1);
            att = (first_ok <= MR + 1) ? first_ok : MR + 1;
            ed = (first_ok <= MR + 1) ? 1 : 0;
            ec = att * (PW + ST + 1) + 1;
            ep = att;
        end
    endfunction

    task automatic run_req(input bit v, input string name,
                           input int edone, input int ecyc, input int ep);
        int s0;
        int r0;
        int cyc;
        int dn;
        int er;
        int rdy;
        int tail;
        s0 = s_rise;
        r0 = r_rise;
        cyc = 0;
        dn = 0;
        er = 0;
        rdy = 0;
        @(negedge clock);
        req_valid = 1'b1;
        req_value = v;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_value = 1'($urandom);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (done || error) begin
                cyc = c;
                dn = int'(done);
                er = int'(error);
                rdy = int'(req_ready);
                break;
            end
        end
        @(negedge clock);
        tail = int'(done | error);
        check({name, " cycle"}, cyc, ecyc);
        check({name, " done"}, dn, edone);
        check({name, " error"}, er, 1 - edone);
        check({name, " ready"}, rdy, 1);
        check({name, " width"}, tail, 0);
        check({name, " pulses"}, v ? s_rise - s0 : r_rise - r0, ep);
        check({name, " other"}, v ? r_rise - r0 : s_rise - s0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit v;
        bit oq;
        bit oqb;
        bit holds;
        int mode;
        int k;
        int ed;
        int ec;
        int ep;
        int d0;
        int e0;

        //            v  ovr k  oq oqb holds done cyc pulses
        tbl[0]  = '{1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1, 5, 1};
        tbl[1]  = '{1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 0, 17, 4};
        tbl[2]  = '{1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1, 5, 1};
        tbl[3]  = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1, 5, 1};
        tbl[4]  = '{1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1, 9, 2};
        tbl[5]  = '{1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1, 17, 4};
        tbl[6]  = '{1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0, 0, 17, 4};
        tbl[7]  = '{1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b0, 0, 17, 4};
        tbl[8]  = '{1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 17, 4};
        tbl[9]  = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1, 5, 1};
        tbl[10] = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1, 5, 1};

        repeat (3) @(negedge clock);
        check("reset outputs", int'({s, r, done, error, busy, req_ready}), 1);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        check("idle outputs", int'({s, r, done, error, busy, req_ready}), 1);

        for (int i = 0; i < 11; i++) begin
            configure(tbl[i].ovr, tbl[i].k, tbl[i].oq, tbl[i].oqb);
            if (SKIP && tbl[i].holds) begin
                run_req(tbl[i].v, $sformatf("vec%0d", i), 1, 1, 0);
            end else begin
                run_req(tbl[i].v, $sformatf("vec%0d", i),
                        tbl[i].edone, tbl[i].ecyc, tbl[i].ep);
            end
        end

        configure(1'b0, 0, 1'b0, 1'b0);
        v = ~q_m;
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clock);
        req_valid = 1'b1;
        req_value = v;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("abort pulse active", int'(v ? s : r), 1);
        #2;
        reset = 1'b1;
        #1;
        check("abort async drop", int'({s, r, busy, req_ready}), 1);
        @(negedge clock);
        reset = 1'b0;
        repeat (8) @(negedge clock);
        check("abort no completion", (done_cnt - d0) + (err_cnt - e0), 0);
        v = ~q_m;
        predict(1'b0, 1'b0, 0, ed, ec, ep);
        run_req(v, "rerequest", ed, ec, ep);

        for (int i = 0; i < 25; i++) begin
            mode = int'($urandom_range(0, 2));
            v = 1'($urandom_range(0, 1));
            oq = 1'($urandom_range(0, 1));
            oqb = 1'($urandom_range(0, 1));
            k = (mode == 1) ? int'($urandom_range(1, 5)) : 0;
            if (mode == 2) begin
                configure(1'b1, 0, oq, oqb);
                holds = (oq == v) && (oqb != v);
            end else begin
                configure(1'b0, k, 1'b0, 1'b0);
                holds = (q_m == v);
            end
            predict(holds, mode == 2, k, ed, ec, ep);
            run_req(v, $sformatf("rand%0d", i), ed, ec, ep);
        end

        check("invariants", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
